// File: rtl/oz_coloring_if.sv
// ---------------------------------------------------------------------------
// oz_coloring_if
//
// Valid/ready stream carrying one four-colour assignment of the five Oz
// regions per transfer. A transfer completes on a rising clock edge where
// out_valid and out_ready are both high.
//
// Signals:
//   out_valid  producer -> consumer  out_color holds a valid colouring
//   out_ready  consumer -> producer  consumer accepts out_color this cycle
//   out_color  producer -> consumer  {GC, WC, QC, MC, EC}, 2 bits each,
//                                    GC in [9:8], EC in [1:0]
//
// Modports:
//   master  the search engine (drives out_valid / out_color)
//   slave   the downstream consumer (drives out_ready)
// ---------------------------------------------------------------------------
interface oz_coloring_if;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_color;

    modport master (
        output out_valid,
        output out_color,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_color,
        output out_ready
    );
endinterface : oz_coloring_if

// File: rtl/oz_coloring_search.sv
// ---------------------------------------------------------------------------
// oz_coloring_search
//
// Exhaustive search over the 1024 candidate colourings of the five Oz
// regions (Gillikin, Winkie, Quadling, Munchkin, Emerald City), one
// candidate per clock. Candidates satisfying all eight adjacency
// inequalities are loaded into a single output register and streamed out
// over a valid/ready handshake. Solutions are counted and completion is
// flagged.
//
// Adjacency: GC-WC, WC-QC, QC-MC, MC-GC, and EC touches all four others.
//
// Parameters:
//   CNT_W       width of the solution counter (>= 7; 72 solutions exist)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       begin a new search (sampled only in IDLE or DONE)
//   abort       return to IDLE next cycle; overrides everything but rst
//   first_only  stop after the first solution (captured with start)
//   bus         oz_coloring_if.master: out_valid / out_ready / out_color
//   sol_count   solutions loaded into the output register this search
//   busy        high while scanning or draining the output register
//   done        high (level) once the search has finished
// ---------------------------------------------------------------------------
module oz_coloring_search #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              first_only,
    oz_coloring_if.master     bus,
    output logic [CNT_W-1:0]  sol_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [9:0]       IDX_LAST = 10'h3FF;

    state_t             state_q;
    state_t             state_d;
    logic [9:0]         idx_q;
    logic               out_valid_q;
    logic [9:0]         out_color_q;
    logic [CNT_W-1:0]   sol_count_q;
    logic               first_only_q;

    // ------------------------------------------------------------------
    // Candidate evaluation (purely from the idx register, so nothing
    // combinational reaches the outputs from idx)
    // ------------------------------------------------------------------
    logic [1:0] gc, wc, qc, mc, ec;
    logic       cand_ok;
    logic       reg_free;
    logic       load;
    logic       last_idx;
    logic       scan_end;
    logic       can_start;

    assign gc = idx_q[9:8];
    assign wc = idx_q[7:6];
    assign qc = idx_q[5:4];
    assign mc = idx_q[3:2];
    assign ec = idx_q[1:0];

    assign cand_ok = (gc != wc) && (wc != qc) && (qc != mc) && (mc != gc) &&
                     (ec != gc) && (ec != wc) && (ec != qc) && (ec != mc);

    // The output register can take a new value if it is empty or its
    // current value is being accepted on this same edge.
    assign reg_free  = !out_valid_q || bus.out_ready;
    assign load      = (state_q == S_SCAN) && cand_ok && reg_free;
    assign last_idx  = (idx_q == IDX_LAST);
    assign can_start = (state_q == S_IDLE) || (state_q == S_DONE);

    // Leave SCAN once the final index has been dealt with (skipped, or
    // loaded), or right after the first load in first-only mode.
    assign scan_end = (state_q == S_SCAN) &&
                      ((last_idx && (!cand_ok || reg_free)) ||
                       (first_only_q && load));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE,
                S_DONE:  if (start)    state_d = S_SCAN;
                S_SCAN:  if (scan_end) state_d = S_DRAIN;
                S_DRAIN: if (reg_free) state_d = S_DONE;
                default:               state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SCAN,
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: candidate index, output register, solution counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_color_q  <= '0;
            sol_count_q  <= '0;
            first_only_q <= 1'b0;
        end else if (abort) begin
            // The count is left alone so software can see how far the
            // aborted search got.
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_color_q  <= '0;
            first_only_q <= 1'b0;
        end else if (can_start && start) begin
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            sol_count_q  <= '0;
            first_only_q <= first_only;
        end else begin
            if (load) begin
                out_color_q <= idx_q;
                out_valid_q <= 1'b1;
                if (sol_count_q != CNT_MAX) begin
                    sol_count_q <= sol_count_q + CNT_W'(1);
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // Advance unless stalled on a valid candidate; the index
            // parks at its final value instead of wrapping.
            if ((state_q == S_SCAN) && (!cand_ok || reg_free) && !last_idx) begin
                idx_q <= idx_q + 10'd1;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_color = out_color_q;
    assign sol_count     = sol_count_q;

endmodule : oz_coloring_search

// File: tb/tb_oz_coloring_search.sv
// ---------------------------------------------------------------------------
// tb_oz_coloring_search
//
// Directed bench for oz_coloring_search. Inputs change 1 time unit after a
// rising edge; transfers are captured on the falling edge, when the
// handshake values that the next rising edge will act on are settled.
// Hand-computed reference points: 72 solutions, first 0x046, 10th 0x08D,
// last 0x3B9, DONE visible 1026 edges after start is first driven.
// ---------------------------------------------------------------------------
module tb_oz_coloring_search;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       first_only;
    logic [7:0] sol_count;
    logic       busy;
    logic       done;

    oz_coloring_if bus();

    oz_coloring_search #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_only (first_only),
        .bus        (bus),
        .sol_count  (sol_count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] xfers[$];
    logic [9:0] exp_q[$];

    // Independent colouring rule: regions 0..4 are G, W, Q, M, E; each pair
    // listed below shares a border and must differ.
    function automatic bit ok_model(input logic [9:0] c);
        logic [1:0] r[5];
        int         a[8] = '{0, 1, 2, 3, 4, 4, 4, 4};
        int         b[8] = '{1, 2, 3, 0, 0, 1, 2, 3};
        for (int i = 0; i < 5; i++) r[i] = c[9-2*i -: 2];
        for (int e = 0; e < 8; e++) begin
            if (r[a[e]] == r[b[e]]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer side: record every completed transfer.
    always @(negedge clk) begin
        if (!rst && !abort && bus.out_valid && bus.out_ready)
            xfers.push_back(bus.out_color);
    end

    task automatic do_start(input bit fo);
        xfers.delete();
        start      = 1'b1;
        first_only = fo;
        tick();
        start      = 1'b0;
        first_only = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("done_after_start", 32'(done), 0);
    endtask

    // Wait for done; optionally pulse start once mid-search (pulse_at > 1).
    task automatic wait_done(input int pulse_at, output int cyc);
        cyc = 1;
        while (!done && cyc < 3000) begin
            start = (cyc == pulse_at);
            tick();
            cyc++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 32'(done), 1);
    endtask

    task automatic check_full(input string tag);
        bit seen[1024];
        int errs;
        int bad_model;
        int bad_skip;
        int n_uniq;
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        check({tag, "_n_xfer"}, 32'(xfers.size()), 72);
        errs = 0;
        bad_model = 0;
        n_uniq = 0;
        for (int i = 0; i < xfers.size(); i++) begin
            if (i >= exp_q.size() || xfers[i] !== exp_q[i]) errs++;
            if (!ok_model(xfers[i])) bad_model++;
            if (!seen[xfers[i]]) n_uniq++;
            seen[xfers[i]] = 1'b1;
        end
        bad_skip = 0;
        for (int i = 0; i < 1024; i++) begin
            if (!seen[i] && ok_model(i[9:0])) bad_skip++;
        end
        check({tag, "_order_err"}, 32'(errs), 0);
        check({tag, "_xfer_invalid"}, 32'(bad_model), 0);
        check({tag, "_skipped"}, 32'(1024 - n_uniq), 952);
        check({tag, "_skipped_valid"}, 32'(bad_skip), 0);
        if (xfers.size() > 0) begin
            check({tag, "_first"}, 32'(xfers[0]), 32'h046);
            check({tag, "_last"}, 32'(xfers[xfers.size()-1]), 32'h3B9);
        end
        check({tag, "_sol_count"}, 32'(sol_count), 72);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_valid"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        int         cyc;
        int         k;
        int         n0;
        logic [9:0] c0;
        logic [7:0] s0;

        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        first_only    = 1'b0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            if (ok_model(i[9:0])) exp_q.push_back(i[9:0]);
        end
        check("model_count", 32'(exp_q.size()), 72);

        // Reset state
        #3;
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_color", 32'(bus.out_color), 0);
        check("rst_count", 32'(sol_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        tick();
        rst = 1'b0;
        tick();

        // Free-running full search
        do_start(1'b0);
        wait_done(0, cyc);
        check("full_cycles", 32'(cyc), 1026);
        check_full("full");

        // Backpressure: hold out_ready low 5 cycles with data pending
        do_start(1'b0);
        k = 0;
        while (!(bus.out_valid && sol_count >= 8'd20) && k < 600) begin
            tick();
            k++;
        end
        check("bp_reached", 32'(bus.out_valid), 1);
        c0 = bus.out_color;
        s0 = sol_count;
        n0 = xfers.size();
        bus.out_ready = 1'b0;
        repeat (5) begin
            tick();
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_color_hold", 32'(bus.out_color), 32'(c0));
            check("bp_count_hold", 32'(sol_count), 32'(s0));
        end
        check("bp_no_xfer", 32'(xfers.size()), 32'(n0));
        bus.out_ready = 1'b1;
        wait_done(0, cyc);
        check_full("bp");

        // first_only
        do_start(1'b1);
        wait_done(0, cyc);
        check("fo_n_xfer", 32'(xfers.size()), 1);
        if (xfers.size() > 0) check("fo_color", 32'(xfers[0]), 32'h046);
        check("fo_count", 32'(sol_count), 1);
        check("fo_done", 32'(done), 1);

        // Abort after 10 transfers (10th solution is 0x08D; next is 0x09B,
        // so the register is empty for a while after the 10th transfer)
        do_start(1'b0);
        k = 0;
        while (!(sol_count == 8'd10 && !bus.out_valid) && k < 600) begin
            tick();
            k++;
        end
        check("ab_reached", 32'(sol_count), 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_valid", 32'(bus.out_valid), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_done", 32'(done), 0);
        check("ab_count", 32'(sol_count), 10);
        check("ab_n_xfer", 32'(xfers.size()), 10);
        if (xfers.size() >= 10) check("ab_10th", 32'(xfers[9]), 32'h08D);
        tick();
        check("ab_stays_idle", 32'(busy), 0);

        // Restart after abort, with a stray start pulse mid-scan
        do_start(1'b0);
        wait_done(300, cyc);
        check("restart_cycles", 32'(cyc), 1026);
        check_full("restart");

        // Reset mid-search
        do_start(1'b0);
        repeat (400) tick();
        rst = 1'b1;
        #2;
        check("mrst_valid", 32'(bus.out_valid), 0);
        check("mrst_color", 32'(bus.out_color), 0);
        check("mrst_count", 32'(sol_count), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        tick();
        rst = 1'b0;
        tick();
        check("mrst_idle", 32'(busy), 0);
        do_start(1'b0);
        wait_done(0, cyc);
        check_full("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_oz_coloring_search

// File: doc/oz_coloring_search.md
# oz_coloring_search

Sequencing controller for the Land-of-Oz four-colour map checker. On `start` it walks every one of the 1024 candidate colourings of the five regions (Gillikin, Winkie, Quadling, Munchkin, Emerald City), one candidate per cycle. It evaluates the eight adjacency inequalities internally and streams each valid colouring out over a valid/ready handshake. It counts the solutions and flags completion, so the checker datapath can run as an autonomous exhaustive search in front of downstream consumers.

## Interface
Parameters:
- `CNT_W`, default 8: width of solution counter; must be ≥ 7, since 72 solutions exist.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new search. Sampled only in IDLE or DONE.
- `abort` in 1: terminate search. Wins over every other input except `rst`.
- `first_only` in 1: stop after the first solution. Sampled with `start` and held internally.
- `out_valid` out 1: `out_color` holds a valid colouring.
- `out_ready` in 1: consumer accepts `out_color` on a cycle when `out_valid & out_ready` are both high.
- `out_color` out 10: {GC, WC, QC, MC, EC}, 2 bits each, GC in [9:8], EC in [1:0].
- `sol_count` out CNT_W: number of solutions loaded into the output register this search.
- `busy` out 1: high in SCAN or DRAIN.
- `done` out 1: high in DONE (level).

## Operation
- Candidate index `idx` is 10 bits, with fields mapped identically to `out_color`.
- A candidate is valid iff all of the following hold: GC≠WC, WC≠QC, QC≠MC, MC≠GC, and EC differs from each of GC, WC, QC and MC.
- States:
  - IDLE: all outputs 0.
  - IDLE/DONE → SCAN on `start`: `idx`←0, `sol_count`←0, `out_valid`←0, `first_only` latched.
  - SCAN, `idx` invalid: `idx`++.
  - SCAN, `idx` valid and output register free: load `out_color`←`idx`, set `out_valid`, `sol_count`++, `idx`++.
    - The output register is free when `!out_valid` or `out_valid & out_ready` in the same cycle.
  - SCAN, `idx` valid and register not free: stall. `idx`, `sol_count` and `out_color` hold.
  - SCAN → DRAIN:
    - after `idx`=1023 is processed (skipped or loaded); `idx` is not wrapped;
    - or, if `first_only` is set, after the first load.
  - DRAIN → DONE when the output register is empty, or is accepted this cycle.
  - DONE: `done`=1, `sol_count` holds the final value, `out_valid`=0.
- `abort` in any state → IDLE next cycle: `out_valid`←0, `busy`←0, `done`←0. `sol_count` holds its value for inspection.
- `start` while SCAN or DRAIN is ignored.
- `out_color` is stable while `out_valid & !out_ready`.
- The counter saturates at 2^CNT_W−1; this is unreachable for legal CNT_W.

## Timing
- Async reset: state IDLE, `idx`=0, `out_valid`=0, `out_color`=0, `sol_count`=0, `busy`=0, `done`=0.
- `start` at edge k: SCAN evaluates `idx`=0 in cycle k+1, and `busy`=1 from k+1.
- A valid candidate evaluated in cycle n makes `out_valid`=1 from cycle n+1. This is a one-register latency with no combinational path from `idx` to outputs.
- With `out_ready` tied high, SCAN lasts exactly 1024 cycles, and the final transfer may coincide with the SCAN→DRAIN edge.
- Simultaneous `start` and `abort`: abort wins, giving IDLE.
- Reset asserted mid-search: immediate return to reset values, with no output transfer completing.

## Test plan
- Full search, `out_ready`=1:
  - exactly 72 transfers;
  - first `out_color`=0x046 (GC0 WC1 QC0 MC1 EC2), last =0x3B9 (GC3 WC2 QC3 MC2 EC1);
  - `sol_count`=72, `done`=1 about 1026 cycles after `start`.
- Backpressure: drop `out_ready` for 5 cycles while `out_valid`=1. Required: `out_color` stable, `idx` stalled, every transfer unique, total count 72, same order as the free-running case.
- `first_only`=1: exactly one transfer, 0x046, then DONE with `sol_count`=1.
- `abort` after 10 transfers: next cycle `out_valid`=0, `busy`=0, `done`=0, `sol_count`=10. A new `start` then yields the full 72 again.
- `start` pulsed during SCAN has no effect. Reset pulsed mid-search gives all outputs 0; a restart reproduces the full sequence.
- Scoreboard check: every transferred colouring passes an independent eight-inequality model, and all 952 skipped indices fail it.
